f8_reset_supervisor: RTL and testbench



---
 rtl/f8_supervisor_pkg.sv | 18 +
 rtl/f8_reset_sync.sv | 24 ++
 rtl/f8_reset_supervisor.sv | 107 ++++++++++
 tb/tb_f8_reset_supervisor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/f8_supervisor_pkg.sv
// Shared types and defaults for the f8 reset/trap supervisor.
package f8_supervisor_pkg;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_HOLDOFF,
        ST_HALT
    } state_t;

    localparam int DEF_POR_CYCLES   = 5;
    localparam int DEF_TRAP_HOLDOFF = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/f8_reset_sync.sv
// Two-flop reset synchroniser: asynchronous assertion, synchronous release.
module f8_reset_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic s1;
    logic s2;

    // NOTE: non-blocking assignments make s2 take the old s1, giving two real stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= 1'b1;
            s2 <= s1;
        end
    end

    assign rst_sync_n = s2;

endmodule

// File: rtl/f8_reset_supervisor.sv
// Board reset stretcher and trap supervisor for the f8 system.
// Define F8_TRAP_HALT_EN to park the system in HALT after a trap instead of restarting it.
module f8_reset_supervisor
    import f8_supervisor_pkg::*;
#(
    parameter int POR_CYCLES   = DEF_POR_CYCLES,
    parameter int TRAP_HOLDOFF = DEF_TRAP_HOLDOFF,
    parameter int COUNT_W      = 8
) (
    input  logic               clk,
    input  logic               power_on_reset_n,
    input  logic               trap,
    input  logic               clear_count,
    output logic               system_reset,
    output logic [COUNT_W-1:0] trap_count,
    output logic               halted
);

    localparam int CNT_W = $clog2(max_int(POR_CYCLES, TRAP_HOLDOFF) + 1);
    localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TRAP_HOLDOFF - 1);

    logic               rst_sync_n;
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               counted;
    logic [COUNT_W-1:0] count_next;

    f8_reset_sync u_reset_sync (
        .clk        (clk),
        .rst_n      (power_on_reset_n),
        .rst_sync_n (rst_sync_n)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        counted    = (state == ST_RUN) && trap;
        count_next = trap_count;
        if (clear_count) begin
            count_next = counted ? COUNT_W'(1) : '0;
        end else if (counted && (trap_count != '1)) begin
            count_next = trap_count + COUNT_W'(1);
        end
    end

    // The board pin reaches these flops through s2, so system_reset rises without a clock.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state        <= ST_RESET;
            cnt          <= '0;
            system_reset <= 1'b1;
            trap_count   <= '0;
`ifdef F8_TRAP_HALT_EN
            halted       <= 1'b0;
`endif
        end else begin
            trap_count <= count_next;
            case (state)
                ST_RESET: begin
                    if (cnt == POR_LAST) begin
                        state        <= ST_RUN;
                        system_reset <= 1'b0;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (trap) begin
                        state <= ST_HOLDOFF;
                        cnt   <= '0;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
`ifdef F8_TRAP_HALT_EN
                        state        <= ST_HALT;
                        halted       <= 1'b1;
`else
                        state        <= ST_RESET;
`endif
                        system_reset <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef F8_TRAP_HALT_EN
                ST_HALT: begin
                    system_reset <= 1'b1;
                    halted       <= 1'b1;
                end
`endif
                default: begin
                    state        <= ST_RESET;
                    system_reset <= 1'b1;
                    cnt          <= '0;
                end
            endcase
        end
    end

`ifndef F8_TRAP_HALT_EN
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_f8_reset_supervisor.sv
// Self-checking bench for f8_reset_supervisor; honours F8_TRAP_HALT_EN when defined.
module tb_f8_reset_supervisor;

    localparam int POR  = 5;
    localparam int HOLD = 5;

    logic       clk = 1'b0;
    logic       pin = 1'b0;
    logic       trap = 1'b0;
    logic       clear = 1'b0;
    logic       sr, sr2, halted, halted2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    f8_reset_supervisor #(.POR_CYCLES(POR), .TRAP_HOLDOFF(HOLD), .COUNT_W(8)) dut (
        .clk(clk), .power_on_reset_n(pin), .trap(trap), .clear_count(clear),
        .system_reset(sr), .trap_count(cnt8), .halted(halted)
    );

    f8_reset_supervisor #(.POR_CYCLES(POR), .TRAP_HOLDOFF(HOLD), .COUNT_W(2)) dut2 (
        .clk(clk), .power_on_reset_n(pin), .trap(trap), .clear_count(clear),
        .system_reset(sr2), .trap_count(cnt2), .halted(halted2)
    );

    always #2 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Timeline model: tracks the edge numbers at which system_reset must change.
    int n = 0;
    int fall_edge = -1;
    int rise_edge = 0;
    bit started = 0;
    bit m_sr = 1;
    bit m_halt = 0;
    int m_c8 = 0;
    int m_c2 = 0;

    function automatic int next_count(input int c, input bit hit, input bit clr, input int maxv);
        if (clr) return hit ? 1 : 0;
        if (hit && c < maxv) return c + 1;
        return c;
    endfunction

    always @(posedge clk) begin
        bit hit;
        hit = 0;
        n++;
        if (!pin) begin
            started = 0; m_sr = 1; m_halt = 0; m_c8 = 0; m_c2 = 0;
            rise_edge = 0; fall_edge = -1;
        end else if (!started) begin
            started   = 1;
            fall_edge = n + 1 + POR;
        end else begin
            if (m_halt) begin
                hit = 0;
            end else if (m_sr && n == fall_edge) begin
                m_sr = 0;
            end else if (!m_sr && rise_edge == 0) begin
                if (trap) begin
                    hit = 1;
                    rise_edge = n + HOLD;
                end
            end else if (rise_edge != 0 && n == rise_edge) begin
                m_sr = 1;
                rise_edge = 0;
`ifdef F8_TRAP_HALT_EN
                m_halt = 1;
`else
                fall_edge = n + POR;
`endif
            end
            m_c8 = next_count(m_c8, hit, clear, 255);
            m_c2 = next_count(m_c2, hit, clear, 3);
        end
    end

    always @(negedge clk) begin
        bit e_sr, e_h;
        int e8, e2;
        e_sr = pin ? m_sr : 1'b1;
        e_h  = pin ? m_halt : 1'b0;
        e8   = pin ? m_c8 : 0;
        e2   = pin ? m_c2 : 0;
        check("model_sr", 32'(sr), 32'(e_sr));
        check("model_sr2", 32'(sr2), 32'(e_sr));
        check("model_cnt8", 32'(cnt8), 32'(e8));
        check("model_cnt2", 32'(cnt2), 32'(e2));
        check("model_halted", 32'(halted), 32'(e_h));
        check("model_halted2", 32'(halted2), 32'(e_h));
    end

    task automatic power_on();
        pin = 1'b0;
        step(2);
        pin = 1'b1;
        step(6);
        check("por_edge6_sr", 32'(sr), 32'd1);
        step(1);
        check("por_edge7_sr", 32'(sr), 32'd0);
        check("por_cnt", 32'(cnt8), 32'd0);
    endtask

    initial begin
        #10;
        check("rst_sr", 32'(sr), 32'd1);
        check("rst_cnt", 32'(cnt8), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        #11 pin = 1'b1;
        step(6);
        check("pwr_edge6_sr", 32'(sr), 32'd1);
        step(1);
        check("pwr_edge7_sr", 32'(sr), 32'd0);
        check("pwr_cnt", 32'(cnt8), 32'd0);

        // single trap pulse sampled at edge 8
        trap = 1'b1;
        step(1);
        trap = 1'b0;
        check("trap1_cnt", 32'(cnt8), 32'd1);
        check("trap1_sr", 32'(sr), 32'd0);
        step(4);
        check("hold_end_sr", 32'(sr), 32'd0);
        step(1);
        check("rerst_sr", 32'(sr), 32'd1);
        step(4);
        check("rerst_hold_sr", 32'(sr), 32'd1);
        step(1);
`ifdef F8_TRAP_HALT_EN
        check("halt_sr", 32'(sr), 32'd1);
        check("halt_flag", 32'(halted), 32'd1);
        trap = 1'b1;
        step(20);
        trap = 1'b0;
        check("halt_cnt", 32'(cnt8), 32'd1);
        check("halt_stay", 32'(halted), 32'd1);
        pin = 1'b0;
        #1;
        check("halt_async_sr", 32'(sr), 32'd1);
        check("halt_async_h", 32'(halted), 32'd0);
        power_on();
`else
        check("rerun_sr", 32'(sr), 32'd0);
        // trap held high: counted at edges 19, 30, 41, 52 only
        trap = 1'b1;
        step(1);
        check("held_cnt2", 32'(cnt8), 32'd2);
        step(33);
        trap = 1'b0;
        check("held_cnt5", 32'(cnt8), 32'd5);
        check("sat_cnt2", 32'(cnt2), 32'd3);
        step(10);
        check("rerun2_sr", 32'(sr), 32'd0);
        trap = 1'b1;
        clear = 1'b1;
        step(1);
        trap = 1'b0;
        clear = 1'b0;
        check("clr_trap_cnt8", 32'(cnt8), 32'd1);
        check("clr_trap_cnt2", 32'(cnt2), 32'd1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clr_cnt8", 32'(cnt8), 32'd0);
        check("clr_cnt2", 32'(cnt2), 32'd0);
        // now mid-HOLDOFF: pull the pin and look before the next edge
        pin = 1'b0;
        #1;
        check("async_sr", 32'(sr), 32'd1);
        check("async_cnt", 32'(cnt8), 32'd0);
        power_on();
`endif

        // directed tail, checked by the model only
        step(3);
        trap = 1'b1;
        step(1);
        trap = 1'b0;
        step(7);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(6);
        trap = 1'b1;
        step(2);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(12);
        trap = 1'b0;
        step(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
